// File: rtl/serial_tx_unit_pkg.sv
// rtl/serial_tx_unit_pkg.sv - shared types for the serial TX path
package IO_UnitTypes;
    typedef logic [7:0] SerialDataPath;
endpackage

package SerialTxTypes;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} SerialTxState;

    localparam int SERIAL_TX_DEFAULT_CLK_PER_BIT = 868;
    localparam int SERIAL_TX_COUNT_WIDTH         = 16;

    typedef logic [SERIAL_TX_COUNT_WIDTH-1:0] SerialTxCount;
endpackage

// File: rtl/serial_tx_unit_fifo.sv
// rtl/serial_tx_unit_fifo.sv - byte FIFO between the IO unit writes and the TX serializer
module serial_tx_fifo
    import IO_UnitTypes::*;
#(
    parameter  int FIFO_DEPTH       = 16,
    localparam int FIFO_INDEX_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  SerialDataPath             i_push_data,
    input  logic                      i_pop,
    output SerialDataPath             o_pop_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [FIFO_INDEX_WIDTH:0] o_count
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [FIFO_INDEX_WIDTH:0] r_wr_ptr;
    logic [FIFO_INDEX_WIDTH:0] r_rd_ptr;
    SerialDataPath             r_mem [FIFO_DEPTH];
    logic                      w_do_push;
    logic                      w_do_pop;

    assign o_full  = (r_wr_ptr[FIFO_INDEX_WIDTH-1:0] == r_rd_ptr[FIFO_INDEX_WIDTH-1:0]) &&
                     (r_wr_ptr[FIFO_INDEX_WIDTH] != r_rd_ptr[FIFO_INDEX_WIDTH]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;

    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[FIFO_INDEX_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[FIFO_INDEX_WIDTH-1:0]] <= i_push_data;
    end
endmodule

// File: rtl/serial_tx_unit.sv
// rtl/serial_tx_unit.sv - buffered 8N1 UART transmitter fed by IO unit byte writes
module serial_tx_unit
    import SerialTxTypes::*;
    import IO_UnitTypes::*;
#(
    parameter  int CLK_PER_BIT      = SERIAL_TX_DEFAULT_CLK_PER_BIT,
    parameter  int FIFO_DEPTH       = 16,
    localparam int FIFO_INDEX_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serialWE,
    input  SerialDataPath             serialWriteData,
    input  logic                      overflowClear,
    output logic                      txdOut,
    output logic                      busyOut,
    output logic [FIFO_INDEX_WIDTH:0] fifoCountOut,
    output logic                      overflowOut
);
    localparam SerialTxCount BAUD_LAST = SerialTxCount'(CLK_PER_BIT - 1);

    SerialTxState  r_state;
    SerialTxCount  r_baud_cnt;
    logic [2:0]    r_bit_index;
    SerialDataPath r_shift;
    logic          r_txd;
    logic          r_overflow;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    SerialDataPath w_fifo_head;
    logic          w_baud_done;
    logic          w_pop;
    logic          w_drop;

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    // Popping on the last STOP cycle keeps back-to-back frames contiguous.
    assign w_pop  = !w_fifo_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));
    assign w_drop = serialWE && w_fifo_full;

    serial_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (serialWE),
        .i_push_data (serialWriteData),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (fifoCountOut)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_index <= '0;
            r_shift     <= '0;
            r_txd       <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd      <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift     <= w_fifo_head;
                        r_bit_index <= '0;
                        r_txd       <= 1'b0;
                        r_state     <= START;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_txd      <= r_shift[0];
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt  <= '0;
                        r_shift     <= r_shift >> 1;
                        r_bit_index <= r_bit_index + 3'd1;
                        if (r_bit_index == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift     <= w_fifo_head;
                            r_bit_index <= '0;
                            r_txd       <= 1'b0;
                            r_state     <= START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A drop outranks a same-cycle clear so no overflow event is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflowClear) begin
            r_overflow <= 1'b0;
        end
    end

    assign txdOut      = r_txd;
    assign busyOut     = (r_state != IDLE) || !w_fifo_empty;
    assign overflowOut = r_overflow;
endmodule

// File: tb/tb_serial_tx_unit.sv
// tb/tb_serial_tx_unit.sv - scoreboard bench for serial_tx_unit with a line-side frame decoder
module tb_serial_tx_unit;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       serialWE;
    logic [7:0] serialWriteData;
    logic       overflowClear;
    logic       txdOut;
    logic       busyOut;
    logic [2:0] fifoCountOut;
    logic       overflowOut;

    int         n_vec;
    int         n_mis;
    logic [7:0] exp_q [$];

    serial_tx_unit #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .serialWE        (serialWE),
        .serialWriteData (serialWriteData),
        .overflowClear   (overflowClear),
        .txdOut          (txdOut),
        .busyOut         (busyOut),
        .fifoCountOut    (fifoCountOut),
        .overflowOut     (overflowOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busyOut && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", 32'(busyOut), 32'd0);
        tick(2);
    endtask

    task automatic write_burst(input logic [7:0] first, input int cnt, input int accept);
        for (int i = 0; i < cnt; i++) begin
            serialWE        = 1'b1;
            serialWriteData = first + 8'(i);
            if (i < accept) exp_q.push_back(first + 8'(i));
            tick(1);
        end
        serialWE = 1'b0;
    endtask

    // Line monitor: samples mid-bit, rebuilds each frame and scores it against the queue.
    initial begin
        int         k;
        int         bi;
        logic [7:0] byte_v;
        k = -1;
        byte_v = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                k = -1;
            end else if (k < 0) begin
                if (!txdOut) k = 0;
            end else begin
                k++;
            end
            if (k >= 0 && (k % CPB) == CPB / 2) begin
                bi = k / CPB;
                if (bi >= 1 && bi <= 8) begin
                    byte_v[bi-1] = txdOut;
                end else if (bi == 9) begin
                    chk("stop_bit", 32'(txdOut), 32'd1);
                    if (exp_q.size() == 0)
                        chk("frame_unexpected", {23'd0, 1'b1, byte_v}, 32'd0);
                    else
                        chk("frame_byte", 32'(byte_v), 32'(exp_q.pop_front()));
                    k = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] frame;
        int         low_cnt;
        n_vec           = 0;
        n_mis           = 0;
        rst             = 1'b0;
        serialWE        = 1'b0;
        serialWriteData = '0;
        overflowClear   = 1'b0;
        tick(2);
        chk("rst_txd", 32'(txdOut), 32'd1);
        chk("rst_busy", 32'(busyOut), 32'd0);
        chk("rst_count", 32'(fifoCountOut), 32'd0);
        chk("rst_ovf", 32'(overflowOut), 32'd0);
        rst = 1'b1;
        tick(1);

        // single byte: start, data LSB first, stop
        write_burst(8'hA5, 1, 1);
        chk("single_count", 32'(fifoCountOut), 32'd1);
        chk("single_txd_t", 32'(txdOut), 32'd1);
        tick(1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("single_bit%0d", i), 32'(txdOut), 32'(frame[i]));
            tick(CPB);
        end
        chk("single_busy_end", 32'(busyOut), 32'd0);
        chk("single_count_end", 32'(fifoCountOut), 32'd0);
        tick(2);

        // back-to-back frames with no idle gap
        write_burst(8'h00, 1, 1);
        serialWE = 1'b1;
        serialWriteData = 8'hFF;
        exp_q.push_back(8'hFF);
        tick(1);
        serialWE = 1'b0;
        chk("b2b_start0", 32'(txdOut), 32'd0);
        tick(10 * CPB - 1);
        chk("b2b_last_stop", 32'(txdOut), 32'd1);
        tick(1);
        chk("b2b_start1", 32'(txdOut), 32'd0);
        wait_idle(200);

        // overflow: 6 writes, first pop frees one slot, last byte dropped
        write_burst(8'h10, 6, 5);
        chk("ovf_set", 32'(overflowOut), 32'd1);
        chk("ovf_count", 32'(fifoCountOut), 32'd4);
        tick(10);
        chk("ovf_sticky", 32'(overflowOut), 32'd1);
        overflowClear = 1'b1;
        tick(1);
        overflowClear = 1'b0;
        chk("ovf_clear", 32'(overflowOut), 32'd0);
        wait_idle(400);

        // full FIFO, write lands on the edge where STOP pops
        write_burst(8'h21, 5, 5);
        chk("edge_count_full", 32'(fifoCountOut), 32'd4);
        tick(10 * CPB - 4);
        chk("edge_count_pre", 32'(fifoCountOut), 32'd4);
        chk("edge_ovf_pre", 32'(overflowOut), 32'd0);
        serialWE = 1'b1;
        serialWriteData = 8'h99;
        tick(1);
        serialWE = 1'b0;
        chk("edge_ovf", 32'(overflowOut), 32'd1);
        chk("edge_count_post", 32'(fifoCountOut), 32'd3);
        overflowClear = 1'b1;
        tick(1);
        overflowClear = 1'b0;
        wait_idle(400);

        // asynchronous reset during DATA bit 3 of 0x3C with two bytes queued
        serialWE = 1'b1;
        serialWriteData = 8'h3C;
        tick(1);
        serialWriteData = 8'h41;
        tick(1);
        serialWriteData = 8'h42;
        tick(1);
        serialWE = 1'b0;
        tick(4 * CPB);
        chk("rstmid_bit3", 32'(txdOut), 32'd1);
        chk("rstmid_count_pre", 32'(fifoCountOut), 32'd2);
        rst = 1'b0;
        #1;
        chk("rstmid_txd", 32'(txdOut), 32'd1);
        chk("rstmid_count", 32'(fifoCountOut), 32'd0);
        chk("rstmid_busy", 32'(busyOut), 32'd0);
        tick(3);
        rst = 1'b1;
        low_cnt = 0;
        repeat (60) begin
            tick(1);
            if (!txdOut) low_cnt++;
        end
        chk("rstmid_line_quiet", 32'(low_cnt), 32'd0);
        chk("rstmid_busy_after", 32'(busyOut), 32'd0);

        // clear and drop in the same cycle: set wins
        write_burst(8'h31, 5, 5);
        serialWE = 1'b1;
        serialWriteData = 8'h36;
        overflowClear = 1'b1;
        tick(1);
        serialWE = 1'b0;
        chk("race_set_wins", 32'(overflowOut), 32'd1);
        tick(1);
        overflowClear = 1'b0;
        chk("race_clear_next", 32'(overflowOut), 32'd0);
        wait_idle(400);

        tick(5);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/serial_tx_unit.md
Name: serial_tx_unit

Overview:
- Consumer end of the IO unit's serial output path. Accepts byte writes on serialWE/serialWriteData from the IO unit, buffers them in a FIFO, and serializes them onto a UART TX line.
- Frame format is 8N1, LSB first.
- Sits between the IO unit and the board TX pin, so processor stores to the serial address never stall on line speed.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 16, number of buffered bytes. Power of two, >= 2.
- FIFO_INDEX_WIDTH, $clog2(FIFO_DEPTH), derived; not overridden.

Ports:
- clk  input  1  system clock; everything sampled on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- serialWE  input  1  byte-write strobe from the IO unit; one byte per asserted cycle.
- serialWriteData  input  8 (SerialDataPath)  byte to transmit; valid when serialWE=1.
- overflowClear  input  1  clears the sticky overflow flag.
- txdOut  output  1  UART TX line; idle high.
- busyOut  output  1  1 while a frame is in flight or the FIFO is non-empty.
- fifoCountOut  output  FIFO_INDEX_WIDTH+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflowOut  output  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - txdOut=1, busyOut=0, fifoCountOut=0, overflowOut=0.
  - FSM=IDLE, baud counter=0, FIFO pointers=0.
  - Takes effect immediately, including mid-frame: the partial frame is abandoned and buffered bytes are discarded.
- FIFO:
  - Read/write pointers are FIFO_INDEX_WIDTH+1 bits and wrap naturally. Full when the indices match and the MSBs differ; empty when the pointers are equal.
  - Push: serialWE=1 and not full at the clock edge.
  - serialWE=1 while full: the byte is dropped, the pointers are unchanged, and overflowOut is set on the next edge.
  - Fullness is evaluated before that cycle's pop. A write arriving on the same edge as a pop from a full FIFO is therefore still dropped.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- overflowOut:
  - Cleared by overflowClear=1.
  - If overflowClear and a drop happen in the same cycle, set wins.
- FSM states and transitions:
  - IDLE: txdOut=1. If the FIFO is non-empty, pop the head into the shift register, set bitIndex=0 and counter=0, and go to START.
  - START: txdOut=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: txdOut=shift[0] for CLK_PER_BIT cycles, then shift right and increment bitIndex. Go to STOP after bitIndex=7 completes.
  - STOP: txdOut=1 for CLK_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (frames are contiguous, no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLK_PER_BIT-1.
  - Terminal count (CLK_PER_BIT-1) advances the bit; the counter then resets to 0.
  - Every bit, including start and stop, lasts exactly CLK_PER_BIT cycles. One frame is 10*CLK_PER_BIT cycles.
- txdOut is driven from a register (glitch-free).
- Latency: with the FSM in IDLE and the FIFO empty, a write on edge t gives fifoCountOut=1 after t. The FSM pops on edge t+1, and txdOut falls to 0 after edge t+1 (2 cycles).
- busyOut = (state != IDLE) or FIFO non-empty. It is registered-state-derived combinational logic.
- The byte is latched into the shift register at pop, so data is stable for the whole frame regardless of later FIFO writes.

Decomposition:
- Package SerialTxTypes:
  - enum SerialTxState {IDLE, START, DATA, STOP}.
  - SERIAL_TX_DEFAULT_CLK_PER_BIT constant.
  - SerialTxCount typedef.
- SerialDataPath comes from IO_UnitTypes.
- Sub-module serial_tx_fifo: synchronous FIFO with push/pop/full/empty/count, same clk/rst convention.
- The FSM and baud counter stay in serial_tx_unit.

Test Plan (bench uses CLK_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: write 0xA5 once from idle.
  - txdOut falls 2 cycles later.
  - Sampled every 4 cycles: 0, 1,0,1,0,0,1,0,1, 1 (start, data LSB first, stop).
  - Frame is 40 cycles; then busyOut=0 and fifoCountOut=0.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles.
  - Two contiguous 40-cycle frames with no extra high cycles between the stop bit and the next start bit.
- Overflow: write 6 bytes 0x10..0x15 on consecutive cycles from idle.
  - The first pop frees one slot, so 5 bytes are accepted and 0x15 is dropped.
  - overflowOut=1 and persists until overflowClear=1.
  - Exactly frames 0x10..0x14 appear on txdOut.
- Full-with-pop edge: fill the FIFO to 4 while in the STOP of the previous frame, then write on the exact cycle STOP pops.
  - The write is dropped; overflowOut=1; fifoCountOut goes 4 to 3.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x3C with 2 bytes queued.
  - txdOut=1 immediately (asynchronous); fifoCountOut=0; busyOut=0.
  - After release the line stays high with no frame output.
- Clear/set race: hold overflowClear=1 in the same cycle as a dropped write.
  - overflowOut=1 (set wins); a clear on the next cycle gives 0.
